// File: rtl/iterative_align_shifter.sv
// Multi-cycle variable shifter for the FPU datapath: logical/arithmetic right and
// logical left, moving at most STEP bits per clock and accumulating a sticky bit.
module iterative_align_shifter #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = 6,
  parameter int STEP        = 8
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   start_in,
  input  logic [1:0]             mode_in,
  input  logic [SHAMT_WIDTH-1:0] shiftAmount_in,
  input  logic [WIDTH-1:0]       operand_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [WIDTH-1:0]       operand_out,
  output logic                   stickyBit_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] work;
  logic [1:0]       mode_q;
  logic [CW-1:0]    remaining;
  logic             sticky_acc;

  logic             accept;
  logic [CW-1:0]    a_sat;
  logic [CW-1:0]    step_amt;
  logic             last_step;
  logic [WIDTH-1:0] out_mask;
  logic [WIDTH-1:0] shifted;
  logic             step_sticky;

  always_comb begin
    accept = start_in && (state == IDLE || state == DONE);
    if (32'(shiftAmount_in) >= 32'(WIDTH)) a_sat = CW'(WIDTH);
    else                                   a_sat = CW'(shiftAmount_in);

    step_amt  = (remaining > CW'(STEP)) ? CW'(STEP) : remaining;
    last_step = (remaining <= CW'(STEP));
    // Bits that fall off the LSB end during this step.
    out_mask  = ~({WIDTH{1'b1}} << step_amt);

    shifted     = '0;
    step_sticky = 1'b0;
    case (mode_q)
      2'b00: begin
        shifted     = work >> step_amt;
        step_sticky = |(work & out_mask);
      end
      2'b10: begin
        shifted     = $signed(work) >>> step_amt;
        step_sticky = |(work & out_mask);
      end
      2'b01:   shifted = work << step_amt;
      default: shifted = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_in) state_next = SHIFT;
      SHIFT:   if (last_step) state_next = DONE;
      DONE:    state_next = start_in ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  // Reserved mode is loaded as a zero operand with no distance, so it
  // drains through a single no-op SHIFT cycle and yields 0 / sticky 0.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      work          <= '0;
      mode_q        <= 2'b00;
      remaining     <= '0;
      sticky_acc    <= 1'b0;
      operand_out   <= '0;
      stickyBit_out <= 1'b0;
    end else if (accept) begin
      work       <= (mode_in == 2'b11) ? '0 : operand_in;
      mode_q     <= mode_in;
      remaining  <= (mode_in == 2'b11) ? '0 : a_sat;
      sticky_acc <= 1'b0;
    end else if (state == SHIFT) begin
      work       <= shifted;
      remaining  <= remaining - step_amt;
      sticky_acc <= sticky_acc | step_sticky;
      if (last_step) begin
        operand_out   <= shifted;
        stickyBit_out <= sticky_acc | step_sticky;
      end
    end
  end

  assign busy_out = (state == SHIFT);
  assign done_out = (state == DONE);

endmodule

// File: doc/iterative_align_shifter.md
# iterative_align_shifter

Parametrised multi-cycle shift-and-extend unit for the low-cost FPU datapath. It replaces the fixed 0/16-bit shift-and-extend selector with a variable-amount shifter. Supported modes are logical right, arithmetic right and logical left, each with sticky-bit accumulation on right shifts. The shifter moves at most STEP bits per clock, which trades latency for area. It sits between the operand unpack stage and the adder/normaliser, and is driven by the FPU control FSM through a start/done handshake.

## Interface

Parameters:
- WIDTH, 32: operand and result width in bits.
- SHAMT_WIDTH, 6: width of the shift-amount input.
- STEP, 8: maximum bits shifted per cycle. Must be a power of two, 1 ≤ STEP ≤ WIDTH.

Ports:
- clk_in, input, 1: clock. All state updates on the rising edge.
- reset_in, input, 1: synchronous, active-high reset.
- start_in, input, 1: request a shift. Accepted only when busy_out = 0.
- mode_in, input, 2:
  - 00: logical right.
  - 01: logical left.
  - 10: arithmetic right.
  - 11: reserved.
- shiftAmount_in, input, SHAMT_WIDTH: requested shift distance.
- operand_in, input, WIDTH: value to shift.
- busy_out, output, 1: high while a shift is in progress.
- done_out, output, 1: one-cycle pulse when the result is valid.
- operand_out, output, WIDTH: shifted result (registered).
- stickyBit_out, output, 1: OR of all nonzero bits shifted out on a right shift (registered).

## Operation

- **Reset.** The state machine goes to IDLE. Output values after reset:
  - busy_out = 0, done_out = 0.
  - operand_out = 0, stickyBit_out = 0.
  - Internal remaining-count = 0.
- **State machine** has three states: IDLE, SHIFT and DONE.
  - IDLE and DONE both accept start_in. When start_in is high, the unit:
    - latches operand_in, mode_in and a_sat = min(shiftAmount_in, WIDTH) into working registers;
    - clears the sticky accumulator;
    - goes to SHIFT.
  - SHIFT performs one step per cycle:
    - shift by s = min(STEP, remaining);
    - remaining -= s;
    - for right modes, sticky |= OR of the s bits shifted out;
    - when remaining reaches 0 after the step, go to DONE.
  - DONE lasts exactly one cycle:
    - operand_out and stickyBit_out are loaded from the working registers;
    - done_out = 1;
    - the next state is IDLE, or SHIFT if start_in is high.
- **Zero amount.** If a_sat = 0, SHIFT performs no shift and goes to DONE in the same cycle, so exactly one SHIFT cycle always occurs.
- **Fill bits.**
  - Logical right fills zeros from the MSB side.
  - Arithmetic right fills copies of the latched operand MSB.
  - Left fills zeros from the LSB side, and stickyBit_out is always 0.
- **Saturation.** A shiftAmount_in ≥ WIDTH is treated as WIDTH.
  - Logical right and left results are 0. Arithmetic right gives all sign bits.
  - Sticky for right modes = OR of the whole operand.
- **Reserved mode 11.** Result 0, sticky 0. The shift amount is ignored, so timing is the same as a_sat = 0.
- **Output hold.** operand_out and stickyBit_out hold their value after done_out until the next DONE, or until reset.
- **Busy operation.** start_in is ignored while busy_out = 1. The inputs need not be held stable after the accept cycle.
- **Reset mid-operation** aborts immediately. All outputs return to their reset values on the next edge, and no done_out pulse is produced.

## Timing

- busy_out = 1 exactly in SHIFT cycles. It is 0 in IDLE and DONE.
- start_in accepted at edge N means SHIFT occupies cycles N+1 … N+K, where K = max(1, ceil(a_sat/STEP)). done_out is high in cycle N+K+1.
- With WIDTH=32, STEP=8 the worst case is K=4 (a_sat=32), giving done in cycle N+5.
- Back-to-back operation: start_in in a DONE cycle is accepted. The next SHIFT begins in the following cycle, giving a throughput of one operation per K+1 cycles.
- No combinational path exists from any input to any output.

## Test plan

Defaults for all scenarios: WIDTH=32, STEP=8; start_in accepted at edge N.

1. **Logical right.** mode 00, operand 0x00FF0001, amount 4 → operand_out 0x000FF000, sticky 1, busy in cycle N+1, done in cycle N+2.
2. **Arithmetic right.** mode 10, operand 0x80000010, amount 12 → operand_out 0xFFF80000, sticky 1, done in cycle N+3.
3. **Logical left.** mode 01, operand 0x0000ABCD, amount 16 → operand_out 0xABCD0000, sticky 0, done in cycle N+3.
4. **Saturation.**
   - mode 00, operand 0x00000001, amount 40 → operand_out 0, sticky 1, done in cycle N+5.
   - Mode 10 with operand 0x80000000, amount 63 → operand_out 0xFFFFFFFF, sticky 1.
5. **Zero amount and reserved mode.**
   - Amount 0, mode 00, operand 0x12345678 → operand_out 0x12345678, sticky 0, done in cycle N+2.
   - Mode 11 → operand_out 0, sticky 0, done in cycle N+2.
6. **Handshake and reset.**
   - start_in pulsed while busy with a different operand → ignored; the result matches the first request only.
   - start_in high in the DONE cycle → second result arrives on schedule.
   - reset_in asserted in cycle N+2 of a 4-cycle shift → busy_out, done_out, operand_out and sticky are all 0 from the next cycle, and no done pulse follows.
